// File: rtl/fft_radix2_dit_if.sv
// Handshake and data bundle for the radix-2 DIT butterfly; slave is the butterfly side.
interface fft_radix2_dit_if #(
  parameter int WIDTH = 16
);
  logic                    valid_i;
  logic                    ready_o;
  logic                    inverse_i;
  logic signed [WIDTH-1:0] x1_real_i;
  logic signed [WIDTH-1:0] x1_imag_i;
  logic signed [WIDTH-1:0] x2_real_i;
  logic signed [WIDTH-1:0] x2_imag_i;
  logic signed [WIDTH-1:0] w_real_i;
  logic signed [WIDTH-1:0] w_imag_i;
  logic                    valid_o;
  logic                    ready_i;
  logic signed [WIDTH:0]   X1_real_o;
  logic signed [WIDTH:0]   X1_imag_o;
  logic signed [WIDTH:0]   X2_real_o;
  logic signed [WIDTH:0]   X2_imag_o;
  logic                    ovf_clr_i;
  logic [3:0]              overflow_o;

  modport slave (
    input  valid_i, inverse_i, x1_real_i, x1_imag_i, x2_real_i, x2_imag_i,
           w_real_i, w_imag_i, ready_i, ovf_clr_i,
    output ready_o, valid_o, X1_real_o, X1_imag_o, X2_real_o, X2_imag_o, overflow_o
  );

  modport master (
    output valid_i, inverse_i, x1_real_i, x1_imag_i, x2_real_i, x2_imag_i,
           w_real_i, w_imag_i, ready_i, ovf_clr_i,
    input  ready_o, valid_o, X1_real_o, X1_imag_o, X2_real_o, X2_imag_o, overflow_o
  );
endinterface

// File: rtl/fft_radix2_dit.sv
// Radix-2 DIT butterfly: X1 = x1 + x2*W, X2 = x1 - x2*W, 4-stage pipeline with
// global stall under output backpressure, optional 1/2 scaling and sticky saturation flags.
module fft_radix2_dit #(
  parameter int WIDTH    = 16,
  parameter int WN_WIDTH = 10,
  parameter int SCALE    = 0
) (
  input logic             clk_i,
  input logic             rst_n_i,
  fft_radix2_dit_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int SW = 2 * WIDTH + 1;
  localparam int RW = WIDTH + 2;
  localparam int AW = WIDTH + 3;
  localparam int OW = WIDTH + 1;

  localparam logic signed [SW-1:0]    RND  = SW'(2 ** (WN_WIDTH - 1));
  localparam logic signed [AW-1:0]    MAXV = AW'((2 ** WIDTH) - 1);
  localparam logic signed [AW-1:0]    MINV = AW'(-(2 ** WIDTH));
  localparam logic signed [WIDTH-1:0] MINW = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] MAXW = {1'b0, {(WIDTH-1){1'b1}}};

  logic ce;
  logic v1, v2, v3, valid_q;

  logic signed [WIDTH-1:0] x1r1, x1i1, x1r2, x1i2, x1r3, x1i3;
  logic signed [WIDTH-1:0] x2r1, x2i1, wr1, wi1;
  logic signed [WIDTH-1:0] wi_in;
  logic signed [PW-1:0]    p_rr2, p_ii2, p_ri2, p_ir2;
  logic signed [SW-1:0]    pr_full, pi_full, pr_sh, pi_sh;
  logic signed [RW-1:0]    pr3, pi3;
  logic signed [AW-1:0]    s_c [4];
  logic signed [AW-1:0]    t_c;
  logic signed [OW-1:0]    o_c [4];
  logic [3:0]              f_c;
  logic signed [OW-1:0]    out_q [4];
  logic [3:0]              ovf_q;

  assign ce          = !valid_q | bus.ready_i;
  assign bus.ready_o = ce;

  // Conjugation for the inverse path; the most negative imag part saturates instead of wrapping.
  always_comb begin
    wi_in = bus.w_imag_i;
    if (bus.inverse_i) begin
      wi_in = (bus.w_imag_i == MINW) ? MAXW : -bus.w_imag_i;
    end
  end

  always_comb begin
    pr_full = SW'(p_rr2) - SW'(p_ii2);
    pi_full = SW'(p_ri2) + SW'(p_ir2);
    pr_sh   = (pr_full + RND) >>> WN_WIDTH;
    pi_sh   = (pi_full + RND) >>> WN_WIDTH;
  end

  always_comb begin
    s_c[0] = AW'(x1r3) + AW'(pr3);
    s_c[1] = AW'(x1i3) + AW'(pi3);
    s_c[2] = AW'(x1r3) - AW'(pr3);
    s_c[3] = AW'(x1i3) - AW'(pi3);
    f_c    = '0;
    t_c    = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      t_c = s_c[k];
      if (SCALE != 0) begin
        t_c = (t_c + AW'(1)) >>> 1;
      end
      if (t_c > MAXV) begin
        t_c    = MAXV;
        f_c[k] = 1'b1;
      end else if (t_c < MINV) begin
        t_c    = MINV;
        f_c[k] = 1'b1;
      end
      o_c[k] = t_c[OW-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      valid_q <= 1'b0;
      x1r1    <= '0;
      x1i1    <= '0;
      x1r2    <= '0;
      x1i2    <= '0;
      x1r3    <= '0;
      x1i3    <= '0;
      x2r1    <= '0;
      x2i1    <= '0;
      wr1     <= '0;
      wi1     <= '0;
      p_rr2   <= '0;
      p_ii2   <= '0;
      p_ri2   <= '0;
      p_ir2   <= '0;
      pr3     <= '0;
      pi3     <= '0;
      for (int unsigned k = 0; k < 4; k++) out_q[k] <= '0;
      ovf_q   <= '0;
    end else begin
      if (ce) begin
        v1      <= bus.valid_i;
        v2      <= v1;
        v3      <= v2;
        valid_q <= v3;
        x1r1    <= bus.x1_real_i;
        x1i1    <= bus.x1_imag_i;
        x2r1    <= bus.x2_real_i;
        x2i1    <= bus.x2_imag_i;
        wr1     <= bus.w_real_i;
        wi1     <= wi_in;
        x1r2    <= x1r1;
        x1i2    <= x1i1;
        p_rr2   <= PW'(x2r1) * PW'(wr1);
        p_ii2   <= PW'(x2i1) * PW'(wi1);
        p_ri2   <= PW'(x2r1) * PW'(wi1);
        p_ir2   <= PW'(x2i1) * PW'(wr1);
        x1r3    <= x1r2;
        x1i3    <= x1i2;
        pr3     <= pr_sh[RW-1:0];
        pi3     <= pi_sh[RW-1:0];
        if (v3) begin
          for (int unsigned k = 0; k < 4; k++) out_q[k] <= o_c[k];
        end
      end
      // Clear first so a flag raised in the same cycle survives.
      ovf_q <= (ovf_q & ~{4{bus.ovf_clr_i}}) | ((ce && v3) ? f_c : 4'b0);
    end
  end

  assign bus.valid_o    = valid_q;
  assign bus.X1_real_o  = out_q[0];
  assign bus.X1_imag_o  = out_q[1];
  assign bus.X2_real_o  = out_q[2];
  assign bus.X2_imag_o  = out_q[3];
  assign bus.overflow_o = ovf_q;
endmodule

// File: tb/tb_fft_radix2_dit.sv
// Bench for fft_radix2_dit: unscaled and scaled instances driven in lockstep, checked against an arithmetic model.
module tb_fft_radix2_dit;
  localparam int W  = 16;
  localparam int WN = 10;

  typedef logic [3:0][W:0] quad_t;
  typedef struct packed {
    quad_t      v0;
    quad_t      v1;
    logic [3:0] f0;
    logic [3:0] f1;
    int         t;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_radix2_dit_if #(.WIDTH(W)) bus0 ();
  fft_radix2_dit_if #(.WIDTH(W)) bus1 ();

  assign bus1.valid_i   = bus0.valid_i;
  assign bus1.inverse_i = bus0.inverse_i;
  assign bus1.x1_real_i = bus0.x1_real_i;
  assign bus1.x1_imag_i = bus0.x1_imag_i;
  assign bus1.x2_real_i = bus0.x2_real_i;
  assign bus1.x2_imag_i = bus0.x2_imag_i;
  assign bus1.w_real_i  = bus0.w_real_i;
  assign bus1.w_imag_i  = bus0.w_imag_i;
  assign bus1.ready_i   = bus0.ready_i;
  assign bus1.ovf_clr_i = bus0.ovf_clr_i;

  fft_radix2_dit #(.WIDTH(W), .WN_WIDTH(WN), .SCALE(0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus0.slave));
  fft_radix2_dit #(.WIDTH(W), .WN_WIDTH(WN), .SCALE(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus1.slave));

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    pushes = 0;
  int    ready_low = 0;
  int    last_t = 0;
  exp_t  q[$];
  logic [3:0] oe0 = '0, oe1 = '0;
  bit    shown = 0, clr_prev = 0, stall_prev = 0;
  quad_t held0, held1, last0, last1;

  function automatic quad_t mk(input longint a, input longint b, input longint c, input longint d);
    quad_t r;
    r[0] = 17'(a); r[1] = 17'(b); r[2] = 17'(c); r[3] = 17'(d);
    return r;
  endfunction

  // Butterfly arithmetic straight from the defining equations.
  function automatic void model(input longint x1r, input longint x1i, input longint x2r,
                                input longint x2i, input longint wr, input longint wi,
                                input bit inv, input bit scale, output quad_t o, output logic [3:0] f);
    longint wie, pr, pi, s;
    longint r[4];
    wie = inv ? ((wi == -(2 ** (W - 1))) ? (2 ** (W - 1)) - 1 : -wi) : wi;
    pr  = x2r * wr - x2i * wie;
    pi  = x2r * wie + x2i * wr;
    pr  = (pr + (2 ** (WN - 1))) >>> WN;
    pi  = (pi + (2 ** (WN - 1))) >>> WN;
    pr  = (pr <<< (64 - (W + 2))) >>> (64 - (W + 2));
    pi  = (pi <<< (64 - (W + 2))) >>> (64 - (W + 2));
    r[0] = x1r + pr; r[1] = x1i + pi; r[2] = x1r - pr; r[3] = x1i - pi;
    f = '0;
    for (int k = 0; k < 4; k++) begin
      s = r[k];
      if (scale) s = (s + 1) >>> 1;
      if (s > (2 ** W) - 1) begin s = (2 ** W) - 1; f[k] = 1'b1; end
      else if (s < -(2 ** W)) begin s = -(2 ** W); f[k] = 1'b1; end
      o[k] = 17'(s);
    end
  endfunction

  function automatic longint rs(input int lo, input int hi);
    return longint'($urandom_range(0, hi - lo)) + longint'(lo);
  endfunction

  task automatic set_beat(input longint x1r, input longint x1i, input longint x2r,
                          input longint x2i, input longint wr, input longint wi, input bit inv);
    bus0.valid_i   = 1'b1;
    bus0.x1_real_i = 16'(x1r); bus0.x1_imag_i = 16'(x1i);
    bus0.x2_real_i = 16'(x2r); bus0.x2_imag_i = 16'(x2i);
    bus0.w_real_i  = 16'(wr);  bus0.w_imag_i  = 16'(wi);
    bus0.inverse_i = inv;
  endtask

  task automatic step();
    quad_t d0, d1, m0, m1;
    logic [3:0] g0, g1;
    exp_t e;
    @(negedge clk);
    cyc++;
    d0 = {bus0.X2_imag_o, bus0.X2_real_o, bus0.X1_imag_o, bus0.X1_real_o};
    d1 = {bus1.X2_imag_o, bus1.X2_real_o, bus1.X1_imag_o, bus1.X1_real_o};
    if (rst_n) begin
      if (!bus0.ready_o) ready_low++;
      checks++;
      assert (bus0.ready_o === (!bus0.valid_o || bus0.ready_i))
        else begin errors++; $error("FAIL ready_o obs=%b exp=%b", bus0.ready_o, !bus0.valid_o || bus0.ready_i); end
      checks++;
      assert (bus1.valid_o === bus0.valid_o)
        else begin errors++; $error("FAIL valid_scaled obs=%b exp=%b", bus1.valid_o, bus0.valid_o); end
      if (stall_prev) begin
        checks++;
        assert (bus0.valid_o === 1'b1 && d0 === held0 && d1 === held1)
          else begin errors++; $error("FAIL stall_hold obs=%h/%h exp=%h/%h", d0, d1, held0, held1); end
      end
      if (clr_prev) begin oe0 = '0; oe1 = '0; end
      if (bus0.valid_o && !shown) begin
        checks++;
        assert (q.size() != 0)
          else begin errors++; $error("FAIL spurious_beat obs=valid exp=idle"); end
        if (q.size() != 0) begin
          oe0 |= q[0].f0; oe1 |= q[0].f1; shown = 1;
        end
      end
      checks++;
      assert (bus0.overflow_o === oe0 && bus1.overflow_o === oe1)
        else begin errors++; $error("FAIL overflow obs=%b/%b exp=%b/%b", bus0.overflow_o, bus1.overflow_o, oe0, oe1); end
      if (bus0.valid_o && bus0.ready_i && q.size() != 0) begin
        e = q.pop_front();
        checks++;
        assert (d0 === e.v0 && d1 === e.v1)
          else begin errors++; $error("FAIL beat_data obs=%h/%h exp=%h/%h", d0, d1, e.v0, e.v1); end
        last0 = d0; last1 = d1; last_t = cyc - e.t; shown = 0;
      end
      if (bus0.valid_i && bus0.ready_o) begin
        model(longint'($signed(bus0.x1_real_i)), longint'($signed(bus0.x1_imag_i)),
              longint'($signed(bus0.x2_real_i)), longint'($signed(bus0.x2_imag_i)),
              longint'($signed(bus0.w_real_i)),  longint'($signed(bus0.w_imag_i)),
              bus0.inverse_i, 1'b0, m0, g0);
        model(longint'($signed(bus0.x1_real_i)), longint'($signed(bus0.x1_imag_i)),
              longint'($signed(bus0.x2_real_i)), longint'($signed(bus0.x2_imag_i)),
              longint'($signed(bus0.w_real_i)),  longint'($signed(bus0.w_imag_i)),
              bus0.inverse_i, 1'b1, m1, g1);
        e.v0 = m0; e.v1 = m1; e.f0 = g0; e.f1 = g1; e.t = cyc;
        q.push_back(e);
        pushes++;
      end
      stall_prev = bus0.valid_o && !bus0.ready_i;
      held0 = d0; held1 = d1;
      clr_prev = bus0.ovf_clr_i;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    bus0.valid_i = 1'b0;
    bus0.ready_i = 1'b1;
    for (int i = 0; i < budget && q.size() != 0; i++) step();
    step();
    checks++;
    assert (q.size() == 0)
      else begin errors++; $error("FAIL drain_timeout obs=%0d exp=0", q.size()); end
  endtask

  initial begin
    int stall_left;
    int base;
    bus0.valid_i = 0; bus0.inverse_i = 0; bus0.ready_i = 1; bus0.ovf_clr_i = 0;
    bus0.x1_real_i = '0; bus0.x1_imag_i = '0; bus0.x2_real_i = '0; bus0.x2_imag_i = '0;
    bus0.w_real_i = '0; bus0.w_imag_i = '0;
    repeat (3) step();
    checks++;
    assert (bus0.valid_o === 1'b0 && bus0.overflow_o === 4'b0 && bus0.X1_real_o === 17'sd0 && bus0.ready_o === 1'b1)
      else begin errors++; $error("FAIL reset_state obs=v%b o%b r%b exp=v0 o0 r1", bus0.valid_o, bus0.overflow_o, bus0.ready_o); end
    rst_n = 1;
    step();

    set_beat(100, 0, 50, 0, 1024, 0, 0); step(); drain(10);
    checks++;
    assert (last0 === mk(150, 0, 50, 0) && last_t == 4 && bus0.overflow_o === 4'b0)
      else begin errors++; $error("FAIL t1_basic obs=%h lat=%0d exp=%h lat=4", last0, last_t, mk(150, 0, 50, 0)); end

    set_beat(0, 0, 0, 200, 0, -1024, 0); step(); drain(10);
    checks++;
    assert (last0 === mk(200, 0, -200, 0))
      else begin errors++; $error("FAIL t2_fwd obs=%h exp=%h", last0, mk(200, 0, -200, 0)); end
    set_beat(0, 0, 0, 200, 0, -1024, 1); step(); drain(10);
    checks++;
    assert (last0 === mk(-200, 0, 200, 0))
      else begin errors++; $error("FAIL t2_inv obs=%h exp=%h", last0, mk(-200, 0, 200, 0)); end

    set_beat(32767, 0, 32767, 0, 2047, 0, 0); step(); drain(10);
    checks++;
    assert (last0 === mk(65535, 0, -32735, 0) && bus0.overflow_o === 4'b0001)
      else begin errors++; $error("FAIL t3_sat obs=%h ovf=%b exp=%h ovf=0001", last0, bus0.overflow_o, mk(65535, 0, -32735, 0)); end
    bus0.ovf_clr_i = 1; step(); bus0.ovf_clr_i = 0;
    checks++;
    assert (bus0.overflow_o === 4'b0)
      else begin errors++; $error("FAIL t3_clr obs=%b exp=0000", bus0.overflow_o); end
    step();

    set_beat(3, -3, 0, 0, 1024, 0, 0); step(); drain(10);
    checks++;
    assert (last1 === mk(2, -1, 2, -1))
      else begin errors++; $error("FAIL t4_scale obs=%h exp=%h", last1, mk(2, -1, 2, -1)); end

    set_beat(0, 0, 1, 0, 0, -32768, 1); step(); drain(10);
    checks++;
    assert (last0 === mk(0, 32, 0, -32))
      else begin errors++; $error("FAIL conj_minw obs=%h exp=%h", last0, mk(0, 32, 0, -32)); end

    // Six back-to-back beats with a 3-cycle backpressure window.
    base = pushes; stall_left = -1; ready_low = 0;
    for (int c = 0; c < 40 && (pushes < base + 6 || q.size() != 0); c++) begin
      if (pushes < base + 6)
        set_beat(rs(-32768, 32767), rs(-32768, 32767), rs(-32768, 32767), rs(-32768, 32767),
                 rs(-2047, 2047), rs(-2047, 2047), 1'($urandom_range(0, 1)));
      else bus0.valid_i = 0;
      if (bus0.valid_o && stall_left < 0) stall_left = 3;
      bus0.ready_i = !(stall_left > 0);
      step();
      if (stall_left > 0) stall_left--;
    end
    checks++;
    assert (q.size() == 0 && pushes == base + 6 && ready_low == 3)
      else begin errors++; $error("FAIL t5_stream obs=q%0d n%0d low%0d exp=q0 n6 low3", q.size(), pushes - base, ready_low); end
    drain(10);

    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 9) < 7)
        set_beat(rs(-32768, 32767), rs(-32768, 32767), rs(-32768, 32767), rs(-32768, 32767),
                 rs(-2047, 2047), rs(-2047, 2047), 1'($urandom_range(0, 1)));
      else bus0.valid_i = 0;
      bus0.ready_i   = ($urandom_range(0, 3) != 0);
      bus0.ovf_clr_i = ($urandom_range(0, 19) == 0);
      step();
    end
    bus0.ovf_clr_i = 0;
    drain(40);

    // Mid-stream reset with a sticky flag set and three beats in flight.
    set_beat(32767, 0, 32767, 0, 2047, 0, 0); step(); drain(10);
    for (int i = 0; i < 3; i++) begin
      set_beat(rs(-1000, 1000), 0, rs(-1000, 1000), 0, 1024, 0, 0); step();
    end
    bus0.valid_i = 0;
    rst_n = 0;
    step();
    q.delete(); shown = 0; oe0 = '0; oe1 = '0; stall_prev = 0; clr_prev = 0;
    checks++;
    assert (bus0.valid_o === 1'b0 && bus0.overflow_o === 4'b0 && bus1.overflow_o === 4'b0 &&
            bus0.X1_real_o === 17'sd0 && bus0.X2_real_o === 17'sd0)
      else begin errors++; $error("FAIL t6_reset obs=v%b o%b x%h exp=v0 o0 x0", bus0.valid_o, bus0.overflow_o, bus0.X1_real_o); end
    rst_n = 1;
    repeat (10) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
